ofdm_frame_streamer: RTL and testbench

- Host-side frame driver for the CWGAN-GP core; the transmitting/collecting end of the core's stream interfaces.
- Host preloads one degraded frame and one clean frame into local buffers, then pulses kick.
- Block issues the core start, streams both frames with valid/ready, and captures the reconstructed stream into a result buffer.
- Latches the discriminator scores and reports done/err to the host.

---
 rtl/ofdm_frame_streamer.sv | 185 ++++++++++++++++++
 tb/tb_ofdm_frame_streamer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_frame_streamer.sv
// Host-side frame driver for the CWGAN-GP core: streams preloaded degraded/clean frames, captures recon, latches scores.
// Optional watchdog enabled by defining OFDM_STREAMER_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | host may load buffers; waits for kick
// START     | one-cycle core_start pulse
// STREAM    | degraded (and clean in training) frames sent to the core
// WAIT_DONE | frames sent; waits for core_done
// COMPLETE  | one-cycle done pulse
module ofdm_frame_streamer #(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAME_LEN      = 16,
  parameter int IN_CH          = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int N  = IN_CH * FRAME_LEN,
  localparam int AW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  wr_buf,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  kick,
  input  logic                  kick_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [AW:0]           recon_count,
  output logic [DATA_WIDTH-1:0] score_real_o,
  output logic                  score_real_vld_o,
  output logic [DATA_WIDTH-1:0] score_fake_o,
  output logic                  score_fake_vld_o,
  output logic                  core_start,
  output logic                  core_mode,
  input  logic                  core_busy,
  input  logic                  core_done,
  output logic [DATA_WIDTH-1:0] deg_data,
  output logic                  deg_valid,
  input  logic                  deg_ready,
  output logic [DATA_WIDTH-1:0] clean_data,
  output logic                  clean_valid,
  input  logic                  clean_ready,
  input  logic [DATA_WIDTH-1:0] recon_data,
  input  logic                  recon_valid,
  output logic                  recon_ready,
  input  logic [DATA_WIDTH-1:0] score_real,
  input  logic                  score_real_valid,
  input  logic [DATA_WIDTH-1:0] score_fake,
  input  logic                  score_fake_valid
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_STREAM   = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_COMPLETE = 3'd4;

  localparam logic [AW:0] N_W = (AW + 1)'(N);

  logic [2:0]            state, state_nxt;
  logic [DATA_WIDTH-1:0] deg_mem   [N];
  logic [DATA_WIDTH-1:0] clean_mem [N];
  logic [DATA_WIDTH-1:0] res_mem   [N];
  logic [AW:0]           deg_idx, clean_idx;
  logic                  kick_go, stream_end, rec_hs, rec_full;
  logic                  wd_expire;

  // core_busy is informational only; this block keys purely on core_done.
  logic unused_core_busy;
  assign unused_core_busy = core_busy;

  assign kick_go     = (state == S_IDLE) && kick;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_COMPLETE);
  assign core_start  = (state == S_START);
  assign recon_ready = (state == S_STREAM) || (state == S_WAIT);
  assign deg_valid   = (state == S_STREAM) && (deg_idx != N_W);
  assign clean_valid = (state == S_STREAM) && core_mode && (clean_idx != N_W);
  assign deg_data    = deg_valid   ? deg_mem[deg_idx[AW-1:0]]     : '0;
  assign clean_data  = clean_valid ? clean_mem[clean_idx[AW-1:0]] : '0;
  assign stream_end  = (deg_idx == N_W) && (!core_mode || (clean_idx == N_W));
  assign rec_hs      = recon_valid && recon_ready;
  assign rec_full    = (recon_count == N_W);

`ifdef OFDM_STREAMER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Down-counter loaded on kick; expires on the TIMEOUT_CYCLES-th STREAM/WAIT_DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (kick_go) begin
      wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
    end else if (((state == S_STREAM) || (state == S_WAIT)) && (wd_cnt != '0)) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  assign wd_expire = ((state == S_STREAM) || (state == S_WAIT)) && (wd_cnt == '0);
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (kick) state_nxt = S_START;
      S_START:    state_nxt = S_STREAM;
      S_STREAM: begin
        if (core_done)       state_nxt = S_COMPLETE;
        else if (stream_end) state_nxt = S_WAIT;
      end
      S_WAIT:     if (core_done) state_nxt = S_COMPLETE;
      S_COMPLETE: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (wd_expire) state_nxt = S_COMPLETE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      core_mode        <= 1'b0;
      err              <= 1'b0;
      recon_count      <= '0;
      deg_idx          <= '0;
      clean_idx        <= '0;
      score_real_o     <= '0;
      score_real_vld_o <= 1'b0;
      score_fake_o     <= '0;
      score_fake_vld_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (kick_go) begin
        core_mode        <= kick_mode;
        err              <= 1'b0;
        recon_count      <= '0;
        deg_idx          <= '0;
        clean_idx        <= '0;
        score_real_vld_o <= 1'b0;
        score_fake_vld_o <= 1'b0;
      end else begin
        if (deg_valid && deg_ready)     deg_idx   <= deg_idx + 1'b1;
        if (clean_valid && clean_ready) clean_idx <= clean_idx + 1'b1;
        if (rec_hs) begin
          if (rec_full) err <= 1'b1;
          else          recon_count <= recon_count + 1'b1;
        end
        if ((state == S_STREAM) && core_done) err <= 1'b1;
        if (wd_expire) err <= 1'b1;
        if (busy && score_real_valid) begin
          score_real_o     <= score_real;
          score_real_vld_o <= 1'b1;
        end
        if (busy && score_fake_valid) begin
          score_fake_o     <= score_fake;
          score_fake_vld_o <= 1'b1;
        end
      end
    end
  end

  // Buffers are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE)) begin
      if (wr_buf) clean_mem[wr_addr] <= wr_data;
      else        deg_mem[wr_addr]   <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rec_hs && !rec_full) res_mem[recon_count[AW-1:0]] <= recon_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= res_mem[rd_addr];
  end

endmodule

// File: tb/tb_ofdm_frame_streamer.sv
// Scoreboard bench for ofdm_frame_streamer: directed runs with a simple core model driving ready/recon/done.
module tb_ofdm_frame_streamer;
  localparam int N  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 0, wr_buf = 0, kick = 0, kick_mode = 0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0, rd_data;
  logic busy, done, err, core_start, core_mode;
  logic [AW:0] recon_count;
  logic [15:0] score_real_o, score_fake_o;
  logic score_real_vld_o, score_fake_vld_o;
  logic core_busy = 0, core_done = 0;
  logic [15:0] deg_data, clean_data;
  logic deg_valid, clean_valid, recon_ready;
  logic deg_ready = 1, clean_ready = 1;
  logic [15:0] recon_data = '0, score_real = '0, score_fake = '0;
  logic recon_valid = 0, score_real_valid = 0, score_fake_valid = 0;

  always #5 clk = ~clk;

  ofdm_frame_streamer dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_buf(wr_buf), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .kick(kick),
    .kick_mode(kick_mode), .busy(busy), .done(done), .err(err),
    .recon_count(recon_count), .score_real_o(score_real_o),
    .score_real_vld_o(score_real_vld_o), .score_fake_o(score_fake_o),
    .score_fake_vld_o(score_fake_vld_o), .core_start(core_start),
    .core_mode(core_mode), .core_busy(core_busy), .core_done(core_done),
    .deg_data(deg_data), .deg_valid(deg_valid), .deg_ready(deg_ready),
    .clean_data(clean_data), .clean_valid(clean_valid), .clean_ready(clean_ready),
    .recon_data(recon_data), .recon_valid(recon_valid), .recon_ready(recon_ready),
    .score_real(score_real), .score_real_valid(score_real_valid),
    .score_fake(score_fake), .score_fake_valid(score_fake_valid)
  );

  logic [15:0] deg_m [N];
  logic [15:0] clean_m [N];
  logic [15:0] exp_deg[$];
  logic [15:0] exp_clean[$];
  logic        exp_err[$];
  int n_chk = 0, n_pass = 0;
  int start_cnt = 0, done_cnt = 0, deg_hs = 0;
  logic done_prev = 0;
  int r_sent = 0, r_total = 0;
  logic [15:0] r_base = '0;
  bit bp_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents a beat or a done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start) start_cnt++;
      if (deg_valid && deg_ready) begin
        deg_hs++;
        if (exp_deg.size() == 0) begin
          n_chk++; $display("FAIL deg_extra: unexpected beat %0h", deg_data);
        end else check("deg_data", deg_data, exp_deg.pop_front());
      end
      if (clean_valid && clean_ready) begin
        if (exp_clean.size() == 0) begin
          n_chk++; $display("FAIL clean_extra: unexpected beat %0h", clean_data);
        end else check("clean_data", clean_data, exp_clean.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (done_prev) begin
          n_chk++; $display("FAIL done_width: done high two cycles");
        end
        if (exp_err.size() == 0) begin
          n_chk++; $display("FAIL done_extra: unexpected done pulse");
        end else check("done_err", err, exp_err.pop_front());
      end
      done_prev = done;
    end else done_prev = 0;
  end

  task automatic tick();
    bit rhs;
    rhs = recon_valid && recon_ready;
    @(posedge clk); #1;
    if (rhs) begin
      r_sent++;
      if (r_sent < r_total) recon_data = r_base + 16'(r_sent);
      else recon_valid = 0;
    end
    if (bp_en) begin
      deg_ready = ~deg_ready;
      clean_ready = ~clean_ready;
    end
  endtask

  task automatic setup_recon(input int total, input logic [15:0] base);
    r_sent = 0; r_total = total; r_base = base;
    recon_data = base; recon_valid = (total > 0);
  endtask

  task automatic kick_op(input logic mode);
    for (int i = 0; i < N; i++) begin
      exp_deg.push_back(deg_m[i]);
      if (mode) exp_clean.push_back(clean_m[i]);
    end
    kick = 1; kick_mode = mode;
    tick();
    kick = 0;
    check("start_pulse", core_start, 1);
    check("start_no_deg", deg_valid, 0);
    tick();
    check("start_once", core_start, 0);
    check("first_deg_valid", deg_valid, 1);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    if (done_cnt == d0) begin
      n_chk++; $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic finish_run();
    int i;
    i = 0;
    while (!(exp_deg.size() == 0 && exp_clean.size() == 0 && r_sent >= r_total) && i < 400) begin
      tick(); i++;
    end
    if (i >= 400) begin
      n_chk++; $display("FAIL stream_timeout: deg left %0d clean left %0d", exp_deg.size(), exp_clean.size());
    end
    tick();
    core_done = 1;
    tick();
    core_done = 0;
    wait_done(20);
    tick();
    check("idle_after_done", busy, 0);
  endtask

  task automatic read_res(input int a, input logic [15:0] exp);
    rd_addr = AW'(a);
    tick();
    check("rd_data", rd_data, exp);
  endtask

  initial begin
    #23;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_recon_count", recon_count, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_deg_valid", deg_valid, 0);
    @(posedge clk); #1 rst_n = 1;
    tick();

    for (int i = 0; i < N; i++) begin
      deg_m[i] = 16'(i * 256);
      clean_m[i] = 16'h1000 + 16'(i * 16'h0101);
    end
    wr_en = 1;
    for (int i = 0; i < N; i++) begin
      wr_buf = 0; wr_addr = AW'(i); wr_data = deg_m[i]; tick();
      wr_buf = 1; wr_data = clean_m[i]; tick();
    end
    wr_en = 0;

    // Inference
    setup_recon(32, 16'hA000);
    exp_err.push_back(0);
    kick_op(0);
    finish_run();
    check("inf_recon_count", recon_count, 32);
    check("inf_err", err, 0);
    check("inf_starts", start_cnt, 1);
    read_res(0, 16'hA000);
    read_res(17, 16'hA011);
    read_res(31, 16'hA01F);

    // Training with backpressure and scores
    setup_recon(32, 16'hB000);
    exp_err.push_back(0);
    bp_en = 1;
    kick_op(1);
    tick();
    score_real = 16'h0100; score_real_valid = 1;
    tick();
    score_real_valid = 0; score_fake = 16'hFF00; score_fake_valid = 1;
    tick();
    score_fake_valid = 0;
    finish_run();
    bp_en = 0; deg_ready = 1; clean_ready = 1;
    check("trn_score_real", score_real_o, 16'h0100);
    check("trn_real_vld", score_real_vld_o, 1);
    check("trn_score_fake", score_fake_o, 16'hFF00);
    check("trn_fake_vld", score_fake_vld_o, 1);
    check("trn_recon_count", recon_count, 32);
    read_res(3, 16'hB003);

    // Premature core_done after 10 degraded beats
    begin
      int d0, i;
      setup_recon(0, 16'h0000);
      exp_err.push_back(1);
      d0 = deg_hs;
      kick_op(0);
      check("kick_clears_vld", score_real_vld_o, 0);
      i = 0;
      while (deg_hs - d0 < 10 && i < 100) begin tick(); i++; end
      core_done = 1;
      tick();
      core_done = 0;
      exp_deg.delete();
      wait_done(10);
      tick();
      check("pre_busy", busy, 0);
      check("pre_err_sticky", err, 1);
      check("pre_recon_count", recon_count, 0);
    end

    // Kick and host write while busy
    setup_recon(32, 16'hC000);
    exp_err.push_back(0);
    kick_op(0);
    kick = 1; wr_en = 1; wr_buf = 0; wr_addr = 5'd31; wr_data = 16'h7FFF;
    tick();
    kick = 0; wr_en = 0;
    finish_run();
    check("busy_kick_starts", start_cnt, 4);
    check("busy_err_cleared", err, 0);

    // Recon overflow: 34 beats
    setup_recon(34, 16'hD000);
    exp_err.push_back(1);
    kick_op(0);
    finish_run();
    check("ovf_recon_count", recon_count, 32);
    check("ovf_err", err, 1);
    read_res(31, 16'hD01F);
    read_res(0, 16'hD000);

    // Reset mid-STREAM
    setup_recon(0, 16'h0000);
    kick_op(0);
    tick(); tick();
    rst_n = 0;
    #1;
    check("rst_mid_deg_valid", deg_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_recon_ready", recon_ready, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_recon_count", recon_count, 0);
    exp_deg.delete();
    @(posedge clk); #1 rst_n = 1;
    tick();
    check("rst_mid_idle", busy, 0);

`ifdef OFDM_STREAMER_TIMEOUT_EN
    begin
      int s0;
      s0 = start_cnt;
      setup_recon(0, 16'h0000);
      exp_err.push_back(1);
      kick_op(0);
      wait_done(5000);
      tick();
      check("wd_err", err, 1);
      check("wd_idle", busy, 0);
      check("wd_no_restart", start_cnt, s0 + 1);
      exp_deg.delete();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
